// File: rtl/input_sched_rr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : input_sched_rr_pkg                                        |
// | Description : Shared types and helpers for the input-side scheduler.    |
// |               State encodings and a small width helper.                 |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
package input_sched_rr_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  // Width of a comparison that must hold either operand without truncation.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_sched_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : rr_arbiter                                                |
// | Description : Combinational round-robin arbiter. Grants the first       |
// |               requester strictly after last_idx, wrapping around, by    |
// |               scanning a double-width copy of the request vector.       |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx
);

  logic [2*N-1:0] w_dbl;
  int             w_sel;
  logic           w_found;

  // Lowest set bit above last_idx in {req, req}; the upper copy supplies the wrap.
  always_comb begin
    w_dbl      = {req, req};
    w_sel      = 0;
    w_found    = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (w_dbl[i] && (i > int'(last_idx))) begin
        w_sel   = i;
        w_found = 1'b1;
      end
    end
    if (w_sel >= N) begin
      w_sel = w_sel - N;
    end
    if (w_found) begin
      gnt_idx           = w_sel[IW-1:0];
      gnt_onehot[w_sel] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/input_sched_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : input_sched_rr                                            |
// | Description : Input-side scheduler. Picks a port with a pending         |
// |               descriptor (round robin), waits for shared-buffer space,  |
// |               pops the descriptor and sequences its data words out.     |
// |               Optional: SCHED_STRICT_PRI_EN restricts arbitration to    |
// |               the ports holding the highest pending priority.           |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
module input_sched_rr
  import input_sched_rr_pkg::*;
#(
  parameter int PORT_NUM = 8,
  parameter int DEST_W   = 3,
  parameter int PRI_W    = 3,
  parameter int LEN_W    = 11,
  parameter int FREE_W   = 12
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [PORT_NUM-1:0]                        info_empty,
  input  logic [PORT_NUM*(DEST_W+PRI_W+LEN_W)-1:0]   info_data,
  output logic [PORT_NUM-1:0]                        info_rd_en,
  output logic [PORT_NUM-1:0]                        data_rd_en,
  input  logic [FREE_W-1:0]                          buf_free,
  input  logic                                       wr_ready,
  output logic                                       xfer_start,
  output logic [$clog2(PORT_NUM)-1:0]                xfer_port,
  output logic [DEST_W-1:0]                          xfer_dest,
  output logic [PRI_W-1:0]                           xfer_pri,
  output logic [LEN_W-1:0]                           xfer_len,
  output logic                                       xfer_last,
  output logic                                       busy,
  output logic [15:0]                                drop_cnt
);

  localparam int INFO_W   = DEST_W + PRI_W + LEN_W;
  localparam int LEN_LSB  = 0;
  localparam int PRI_LSB  = LEN_W;
  localparam int DEST_LSB = LEN_W + PRI_W;
  localparam int PW       = $clog2(PORT_NUM);
  localparam int CMP_W    = max_int(FREE_W, LEN_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  // Per-port head descriptors sliced out of the flat bus.
  logic [INFO_W-1:0] w_head [PORT_NUM];
  for (genvar p = 0; p < PORT_NUM; p++) begin : g_head
    assign w_head[p] = info_data[p*INFO_W +: INFO_W];
  end

  logic [PORT_NUM-1:0] w_req;

`ifdef SCHED_STRICT_PRI_EN
  logic [PRI_W-1:0] w_max_pri;

  // Only requesters whose head priority equals the highest pending priority compete.
  always_comb begin
    w_max_pri = '0;
    w_req     = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (!info_empty[p] && (w_head[p][PRI_LSB +: PRI_W] > w_max_pri)) begin
        w_max_pri = w_head[p][PRI_LSB +: PRI_W];
      end
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      w_req[p] = !info_empty[p] && (w_head[p][PRI_LSB +: PRI_W] == w_max_pri);
    end
  end
`else
  assign w_req = ~info_empty;
`endif

  logic [PORT_NUM-1:0] w_gnt_oh;
  logic [PW-1:0]       w_gnt_idx;

  state_t              state_q, state_d;
  logic [PW-1:0]       last_q, last_d;
  logic [PW-1:0]       win_q, win_d;
  logic [PORT_NUM-1:0] win_oh_q, win_oh_d;
  logic [DEST_W-1:0]   hd_dest_q, hd_dest_d;
  logic [PRI_W-1:0]    hd_pri_q, hd_pri_d;
  logic [LEN_W-1:0]    hd_len_q, hd_len_d;
  logic [PW-1:0]       xfer_port_q, xfer_port_d;
  logic [DEST_W-1:0]   xfer_dest_q, xfer_dest_d;
  logic [PRI_W-1:0]    xfer_pri_q, xfer_pri_d;
  logic [LEN_W-1:0]    xfer_len_q, xfer_len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [15:0]         drop_q, drop_d;

  logic [CMP_W-1:0]    w_free_ext;
  logic [CMP_W-1:0]    w_len_ext;

  assign w_free_ext = CMP_W'(buf_free);
  assign w_len_ext  = CMP_W'(hd_len_q);

  rr_arbiter #(
    .N  (PORT_NUM),
    .IW (PW)
  ) u_arb (
    .req        (w_req),
    .last_idx   (last_q),
    .gnt_onehot (w_gnt_oh),
    .gnt_idx    (w_gnt_idx)
  );

  // Next-state logic: arbitrate in IDLE, gate on buffer space in CHECK, stream beats in XFER.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    win_oh_d    = win_oh_q;
    hd_dest_d   = hd_dest_q;
    hd_pri_d    = hd_pri_q;
    hd_len_d    = hd_len_q;
    xfer_port_d = xfer_port_q;
    xfer_dest_d = xfer_dest_q;
    xfer_pri_d  = xfer_pri_q;
    xfer_len_d  = xfer_len_q;
    beat_d      = beat_q;
    drop_d      = drop_q;
    info_rd_en  = '0;
    data_rd_en  = '0;
    xfer_start  = 1'b0;
    xfer_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|w_req) begin
          win_d     = w_gnt_idx;
          win_oh_d  = w_gnt_oh;
          hd_dest_d = w_head[w_gnt_idx][DEST_LSB +: DEST_W];
          hd_pri_d  = w_head[w_gnt_idx][PRI_LSB +: PRI_W];
          hd_len_d  = w_head[w_gnt_idx][LEN_LSB +: LEN_W];
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hd_len_q == '0) begin
          // Empty packet: discard the descriptor without touching the data FIFO.
          info_rd_en = win_oh_q;
          if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
          last_d  = win_q;
          state_d = S_IDLE;
        end else if (w_free_ext >= w_len_ext) begin
          info_rd_en  = win_oh_q;
          xfer_start  = 1'b1;
          xfer_port_d = win_q;
          xfer_dest_d = hd_dest_q;
          xfer_pri_d  = hd_pri_q;
          xfer_len_d  = hd_len_q;
          beat_d      = hd_len_q;
          state_d     = S_XFER;
        end
      end
      S_XFER: begin
        if (wr_ready) begin
          data_rd_en = win_oh_q;
          if (beat_q != '0) begin
            beat_d = beat_q - LEN_ONE;
          end
          if (beat_q == LEN_ONE) begin
            xfer_last = 1'b1;
            last_d    = win_q;
            state_d   = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointer, latched fields and counters; reset leaves port 0 first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= PW'(PORT_NUM - 1);
      win_q       <= '0;
      win_oh_q    <= '0;
      hd_dest_q   <= '0;
      hd_pri_q    <= '0;
      hd_len_q    <= '0;
      xfer_port_q <= '0;
      xfer_dest_q <= '0;
      xfer_pri_q  <= '0;
      xfer_len_q  <= '0;
      beat_q      <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      win_oh_q    <= win_oh_d;
      hd_dest_q   <= hd_dest_d;
      hd_pri_q    <= hd_pri_d;
      hd_len_q    <= hd_len_d;
      xfer_port_q <= xfer_port_d;
      xfer_dest_q <= xfer_dest_d;
      xfer_pri_q  <= xfer_pri_d;
      xfer_len_q  <= xfer_len_d;
      beat_q      <= beat_d;
      drop_q      <= drop_d;
    end
  end

  assign xfer_port = xfer_port_q;
  assign xfer_dest = xfer_dest_q;
  assign xfer_pri  = xfer_pri_q;
  assign xfer_len  = xfer_len_q;
  assign busy      = (state_q != S_IDLE);
  assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_input_sched_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : tb_input_sched_rr                                         |
// | Description : Self-checking bench for input_sched_rr. FIFO heads are    |
// |               modelled with queues; a reference model computes the      |
// |               service order and a monitor checks pops and beats.        |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
module tb_input_sched_rr;

  localparam int PORT_NUM = 8;
  localparam int DEST_W   = 3;
  localparam int PRI_W    = 3;
  localparam int LEN_W    = 11;
  localparam int FREE_W   = 12;
  localparam int INFO_W   = DEST_W + PRI_W + LEN_W;
  localparam int PW       = $clog2(PORT_NUM);

  typedef struct {
    int                port;
    logic [INFO_W-1:0] d;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [PORT_NUM-1:0]          info_empty;
  logic [PORT_NUM*INFO_W-1:0]   info_data;
  logic [PORT_NUM-1:0]          info_rd_en;
  logic [PORT_NUM-1:0]          data_rd_en;
  logic [FREE_W-1:0]            buf_free;
  logic                         wr_ready;
  logic                         xfer_start;
  logic [PW-1:0]                xfer_port;
  logic [DEST_W-1:0]            xfer_dest;
  logic [PRI_W-1:0]             xfer_pri;
  logic [LEN_W-1:0]             xfer_len;
  logic                         xfer_last;
  logic                         busy;
  logic [15:0]                  drop_cnt;

  input_sched_rr #(
    .PORT_NUM (PORT_NUM),
    .DEST_W   (DEST_W),
    .PRI_W    (PRI_W),
    .LEN_W    (LEN_W),
    .FREE_W   (FREE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .info_empty (info_empty),
    .info_data  (info_data),
    .info_rd_en (info_rd_en),
    .data_rd_en (data_rd_en),
    .buf_free   (buf_free),
    .wr_ready   (wr_ready),
    .xfer_start (xfer_start),
    .xfer_port  (xfer_port),
    .xfer_dest  (xfer_dest),
    .xfer_pri   (xfer_pri),
    .xfer_len   (xfer_len),
    .xfer_last  (xfer_last),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus-side FIFOs, pending pushes and reference-model state.
  logic [INFO_W-1:0] fifo [PORT_NUM][$];
  logic [INFO_W-1:0] mq   [PORT_NUM][$];
  logic [INFO_W-1:0] pend_d[$];
  int                pend_p[$];
  bit                flush_req = 1'b0;
  exp_t              sb[$];
  int                last_m = PORT_NUM - 1;
  int                drop_m = 0;

  // Monitor state.
  exp_t cur;
  int   rem = 0;
  bit   in_xfer = 1'b0;
  int   pops_total = 0;
  int   grant_log[$];
  int   load_cyc = 0, pop_cyc = 0, start_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0, beats_seen = 0;

  // Environment control.
  int   env_mode  = 0;
  int   env_free  = 0;
  bit   env_ready = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [INFO_W-1:0] mk(input int dest, input int pri, input int len);
    return {DEST_W'(dest), PRI_W'(pri), LEN_W'(len)};
  endfunction

  function automatic int f_len(input logic [INFO_W-1:0] d);
    return int'(d[LEN_W-1:0]);
  endfunction

  function automatic int f_pri(input logic [INFO_W-1:0] d);
    return int'(d[LEN_W +: PRI_W]);
  endfunction

  function automatic int f_dest(input logic [INFO_W-1:0] d);
    return int'(d[LEN_W+PRI_W +: DEST_W]);
  endfunction

  // FIFO model: pops follow info_rd_en, new descriptors land atomically.
  initial begin
    logic [PORT_NUM-1:0] pm;
    int                  pp;
    logic [INFO_W-1:0]   pd;
    info_empty = '1;
    info_data  = '0;
    forever begin
      @(negedge clk);
      pm = info_rd_en;
      @(posedge clk);
      #1;
      if (flush_req) begin
        for (int p = 0; p < PORT_NUM; p++) fifo[p].delete();
        pend_p.delete();
        pend_d.delete();
        flush_req = 1'b0;
      end else if (!rst) begin
        for (int p = 0; p < PORT_NUM; p++)
          if (pm[p] && fifo[p].size() > 0) void'(fifo[p].pop_front());
      end
      if (pend_p.size() > 0) load_cyc = cyc;
      while (pend_p.size() > 0) begin
        pp = pend_p.pop_front();
        pd = pend_d.pop_front();
        fifo[pp].push_back(pd);
      end
      for (int p = 0; p < PORT_NUM; p++) begin
        info_empty[p] = (fifo[p].size() == 0);
        info_data[p*INFO_W +: INFO_W] = (fifo[p].size() > 0) ? fifo[p][0] : '0;
      end
    end
  end

  // Buffer-space and downstream-ready drive.
  initial begin
    buf_free = '0;
    wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (env_mode)
        1: begin
          buf_free = FREE_W'($urandom_range(0, 20));
          wr_ready = ($urandom_range(0, 3) != 0);
        end
        2: begin
          buf_free = FREE_W'(env_free);
          wr_ready = ~wr_ready;
        end
        default: begin
          buf_free = FREE_W'(env_free);
          wr_ready = env_ready;
        end
      endcase
    end
  end

  task automatic monitor_step();
    exp_t e;
    if (info_rd_en != '0) begin
      pops_total++;
      pop_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_pop", longint'(info_rd_en), 0);
      end else begin
        e = sb.pop_front();
        grant_log.push_back(e.port);
        check("pop_port", longint'(info_rd_en), longint'(1) << e.port);
        check("xfer_start", longint'(xfer_start), (f_len(e.d) != 0) ? 1 : 0);
        if (f_len(e.d) != 0) begin
          cur        = e;
          rem        = f_len(e.d);
          in_xfer    = 1'b1;
          start_cyc  = cyc;
          beats_seen = 0;
        end
      end
    end else if (xfer_start) begin
      check("start_without_pop", longint'(xfer_start), 0);
    end
    if (data_rd_en != '0) begin
      if (!in_xfer) begin
        check("unexpected_beat", longint'(data_rd_en), 0);
      end else begin
        check("beat_port", longint'(data_rd_en), longint'(1) << cur.port);
        check("xfer_port", longint'(xfer_port), cur.port);
        check("xfer_dest", longint'(xfer_dest), f_dest(cur.d));
        check("xfer_pri", longint'(xfer_pri), f_pri(cur.d));
        check("xfer_len", longint'(xfer_len), f_len(cur.d));
        check("xfer_last", longint'(xfer_last), (rem == 1) ? 1 : 0);
        if (beats_seen == 0) first_beat_cyc = cyc;
        beats_seen++;
        last_beat_cyc = cyc;
        rem--;
        if (rem == 0) in_xfer = 1'b0;
      end
    end else if (xfer_last) begin
      check("last_without_beat", longint'(xfer_last), 0);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) monitor_step();
  end

  task automatic queue_desc(input int p, input logic [INFO_W-1:0] d);
    pend_p.push_back(p);
    pend_d.push_back(d);
    mq[p].push_back(d);
  endtask

  // Reference: serve queued descriptors one at a time, round robin from the port after the last served.
  task automatic model_run();
    int   w;
    int   maxp;
    int   p;
    exp_t e;
    do begin
      w    = -1;
      maxp = -1;
`ifdef SCHED_STRICT_PRI_EN
      for (int q = 0; q < PORT_NUM; q++)
        if (mq[q].size() > 0 && f_pri(mq[q][0]) > maxp) maxp = f_pri(mq[q][0]);
`endif
      for (int k = 1; k <= PORT_NUM; k++) begin
        p = (last_m + k) % PORT_NUM;
        if (w < 0 && mq[p].size() > 0 && (maxp < 0 || f_pri(mq[p][0]) == maxp)) w = p;
      end
      if (w >= 0) begin
        e.port = w;
        e.d    = mq[w].pop_front();
        sb.push_back(e);
        last_m = w;
        if (f_len(e.d) == 0 && drop_m < 65535) drop_m++;
      end
    end while (w >= 0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() > 0 || in_xfer || busy || pend_p.size() > 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, (n < 4000) ? 1 : 0, 1);
    @(negedge clk);
    check({name, "_drop_cnt"}, longint'(drop_cnt), drop_m);
  endtask

  task automatic apply_reset(input string name);
    rst       = 1'b1;
    flush_req = 1'b1;
    sb.delete();
    for (int p = 0; p < PORT_NUM; p++) mq[p].delete();
    last_m  = PORT_NUM - 1;
    drop_m  = 0;
    in_xfer = 1'b0;
    #1;
    check({name, "_info_rd_en"}, longint'(info_rd_en), 0);
    check({name, "_data_rd_en"}, longint'(data_rd_en), 0);
    check({name, "_xfer_start"}, longint'(xfer_start), 0);
    check({name, "_xfer_last"}, longint'(xfer_last), 0);
    check({name, "_xfer_fields"}, longint'({xfer_port, xfer_dest, xfer_pri, xfer_len}), 0);
    check({name, "_busy"}, longint'(busy), 0);
    check({name, "_drop_cnt0"}, longint'(drop_cnt), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int p0;
    int t2_exp[6];
    t2_exp = '{0, 2, 7, 0, 2, 7};

    @(posedge clk);
    apply_reset("rst0");

    // T1: single descriptor, latency and beat count.
    env_mode = 0; env_free = 100; env_ready = 1'b1;
    queue_desc(3, mk(5, 2, 4));
    model_run();
    wait_done("t1");
    check("t1_pop_latency", pop_cyc - load_cyc, 1);
    check("t1_first_beat", first_beat_cyc - start_cyc, 1);
    check("t1_beats", beats_seen, 4);
    check("t1_last_beat", last_beat_cyc - start_cyc, 4);

    // T6: reset in the middle of a transfer.
    queue_desc(3, mk(1, 1, 30));
    model_run();
    n = 0;
    while (!(in_xfer && beats_seen >= 3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_mid_xfer", in_xfer, 1);
    #2;
    apply_reset("t6");

    // T2: port 0 must win first after reset, then strict rotation.
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      queue_desc(0, mk(1, 0, 1));
      queue_desc(2, mk(2, 0, 1));
      queue_desc(7, mk(3, 0, 1));
    end
    model_run();
    wait_done("t2");
    check("t2_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("t2_grant%0d", i), grant_log[i], t2_exp[i]);

    // T3: insufficient buffer space holds the descriptor.
    env_free = 20;
    queue_desc(1, mk(4, 3, 50));
    model_run();
    p0 = pops_total;
    repeat (12) @(negedge clk);
    check("t3_no_pop", pops_total - p0, 0);
    check("t3_held_busy", longint'(busy), 1);
    env_free = 50;
    wait_done("t3");
    check("t3_beats", beats_seen, 50);

    // T4: alternating wr_ready.
    env_free = 100;
    env_mode = 2;
    queue_desc(2, mk(6, 3, 6));
    model_run();
    wait_done("t4");
    check("t4_beats", beats_seen, 6);
    check("t4_span", last_beat_cyc - first_beat_cyc, 10);
    env_mode = 0;

    // T5: zero-length descriptor is dropped, next port served.
    grant_log.delete();
    queue_desc(4, mk(0, 1, 0));
    queue_desc(5, mk(2, 1, 3));
    model_run();
    wait_done("t5");
    check("t5_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("t5_first", grant_log[0], 4);
      check("t5_second", grant_log[1], 5);
    end
    check("t5_drop", longint'(drop_cnt), 1);

`ifdef SCHED_STRICT_PRI_EN
    // T7: higher priority wins regardless of pointer.
    grant_log.delete();
    queue_desc(1, mk(0, 1, 5));
    queue_desc(6, mk(0, 4, 5));
    model_run();
    wait_done("t7");
    check("t7_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("t7_first", grant_log[0], 6);
      check("t7_second", grant_log[1], 1);
    end
`endif

    // Randomized batches against the reference model.
    env_mode = 1;
    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        queue_desc($urandom_range(0, PORT_NUM - 1),
                   mk($urandom_range(0, 7), $urandom_range(0, 7),
                      ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12)));
      end
      model_run();
      wait_done($sformatf("rand%0d", b));
    end
    env_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
